// File: rtl/pc_gen.sv
// Registered program-counter stage for the RV32I fetch path: sequential advance,
// branch/JAL/JALR and trap redirects, stall hold, and misaligned-target trapping.
module pc_gen #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VEC  = 32'h0000_0100,
  parameter int              IALIGN    = 32,
  parameter int              STEP      = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            fetch_ready,
  input  logic            stall,
  input  logic            br_taken,
  input  logic            jalr,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1_data,
  input  logic            trap_req,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus,
  output logic            pc_valid,
  output logic            flush,
  output logic            misalign,
  output logic [XLEN-1:0] bad_addr
);

  typedef enum logic [1:0] {BOOT, RUN, TRAPW} state_t;

  state_t          state_q;
  logic [XLEN-1:0] pc_q;
  logic            pc_valid_q;
  logic            flush_q;
  logic            misalign_q;
  logic [XLEN-1:0] bad_addr_q;

  logic [XLEN-1:0] jalr_tgt_d;
  logic [XLEN-1:0] br_tgt_d;
  logic [XLEN-1:0] tgt_d;
  logic            redirect_d;
  logic            tgt_misaligned_d;

  // jalr has precedence over br_taken when both are raised.
  always_comb begin
    jalr_tgt_d       = (rs1_data + imm) & ~XLEN'(1);
    br_tgt_d         = ex_pc + imm;
    tgt_d            = jalr ? jalr_tgt_d : br_tgt_d;
    redirect_d       = jalr | br_taken;
    tgt_misaligned_d = (IALIGN == 16) ? tgt_d[0] : (tgt_d[1:0] != 2'b00);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VEC;
      pc_valid_q <= 1'b0;
      flush_q    <= 1'b0;
      misalign_q <= 1'b0;
      bad_addr_q <= '0;
    end else begin
      flush_q    <= 1'b0;
      misalign_q <= 1'b0;
      case (state_q)
        BOOT: begin
          state_q    <= RUN;
          pc_valid_q <= 1'b1;
        end
        RUN: begin
          if (trap_req) begin
            pc_q    <= TRAP_VEC;
            flush_q <= 1'b1;
          end else if (redirect_d) begin
            flush_q <= 1'b1;
            if (tgt_misaligned_d) begin
              misalign_q <= 1'b1;
              bad_addr_q <= tgt_d;
              pc_q       <= TRAP_VEC;
              pc_valid_q <= 1'b0;
              state_q    <= TRAPW;
            end else begin
              pc_q <= tgt_d;
            end
          end else if (!stall && fetch_ready) begin
            pc_q <= pc_q + XLEN'(STEP);
          end
        end
        TRAPW: begin
          // One idle fetch slot while vectoring; all requests are ignored here.
          state_q    <= RUN;
          pc_valid_q <= 1'b1;
        end
        default: begin
          state_q    <= BOOT;
          pc_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign pc       = pc_q;
  assign pc_plus  = pc_q + XLEN'(STEP);
  assign pc_valid = pc_valid_q;
  assign flush    = flush_q;
  assign misalign = misalign_q;
  assign bad_addr = bad_addr_q;

endmodule
